// File: rtl/cache_controller.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache
// sitting between a pipeline MEM stage and a single-port SRAM controller.
// Load hits complete combinationally; misses and all stores stall the pipeline
// (ready low) until the SRAM controller pulses sram_ready.
module cache_controller #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        sram_wr_en,
    output logic        sram_rd_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_write_data,
    input  logic [31:0] sram_read_data,
    input  logic        sram_ready
);

    localparam int LINES   = 1 << INDEX_BITS;
    localparam int TAG_LSB = INDEX_BITS + 2;

    typedef enum logic [1:0] {StIdle, StRdMiss, StWrThru} state_t;

    state_t state_q, state_d;

    logic [31:0]       addr_q;
    logic [31:0]       data_q;
    logic [LINES-1:0]  valid_q;

    // Tag and data storage carry no reset; valid_q gates every use.
    logic [TAG_BITS-1:0] line_tag  [LINES];
    logic [31:0]         line_data [LINES];

    logic [INDEX_BITS-1:0] req_idx, lat_idx;
    logic [TAG_BITS-1:0]   req_tag, lat_tag;
    logic                  req_hit, lat_hit;

    logic latch_en;
    logic fill_en;
    logic upd_en;

    // Byte-offset bits and any address bits above the tag are not needed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address, addr_q[1:0]};

    assign req_idx = address[INDEX_BITS+1:2];
    assign req_tag = address[TAG_LSB+TAG_BITS-1:TAG_LSB];
    assign lat_idx = addr_q[INDEX_BITS+1:2];
    assign lat_tag = addr_q[TAG_LSB+TAG_BITS-1:TAG_LSB];

    // Lookup for the live request (load hit path) and for the latched store.
    assign req_hit = valid_q[req_idx] && (line_tag[req_idx] == req_tag);
    assign lat_hit = valid_q[lat_idx] && (line_tag[lat_idx] == lat_tag);

    // SRAM side always shows the latched request; latches are zero out of reset.
    assign sram_address    = {2'b00, addr_q[31:2]};
    assign sram_write_data = data_q;

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        latch_en   = 1'b0;
        fill_en    = 1'b0;
        upd_en     = 1'b0;
        ready      = 1'b1;
        read_data  = 32'h0;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Stores win over loads when both are requested.
                if (wr_en) begin
                    ready    = 1'b0;
                    latch_en = 1'b1;
                    state_d  = StWrThru;
                end else if (rd_en) begin
                    if (req_hit) begin
                        read_data = line_data[req_idx];
                    end else begin
                        ready    = 1'b0;
                        latch_en = 1'b1;
                        state_d  = StRdMiss;
                    end
                end
            end
            StRdMiss: begin
                sram_rd_en = 1'b1;
                ready      = sram_ready;
                if (sram_ready) begin
                    read_data = sram_read_data;
                    fill_en   = 1'b1;
                    state_d   = StIdle;
                end
            end
            StWrThru: begin
                sram_wr_en = 1'b1;
                ready      = sram_ready;
                if (sram_ready) begin
                    // No-write-allocate: only refresh a line that already holds this word.
                    upd_en  = lat_hit;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Reset overrides everything combinationally so an abort is visible at once.
        if (!rst) begin
            state_d    = StIdle;
            latch_en   = 1'b0;
            fill_en    = 1'b0;
            upd_en     = 1'b0;
            ready      = 1'b1;
            read_data  = 32'h0;
            sram_rd_en = 1'b0;
            sram_wr_en = 1'b0;
        end
    end

    // State, request latches and valid bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                addr_q <= address;
            end
            if (latch_en && wr_en) begin
                data_q <= write_data;
            end
            if (fill_en) begin
                valid_q[lat_idx] <= 1'b1;
            end
        end
    end

    // Line tag/data storage: filled on a completed read miss, refreshed on a store hit.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            line_tag[lat_idx]  <= lat_tag;
            line_data[lat_idx] <= sram_read_data;
        end else if (upd_en) begin
            line_data[lat_idx] <= data_q;
        end
    end

endmodule
